// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray-code counter family.
//   DEFAULT_WIDTH : default counter / Gray word width
//   MAX_WIDTH     : widest word bin2gray can handle
//   gray_state_t  : counter FSM states (RUN, SAT_HI, SAT_LO)
//   bin2gray      : binary to reflected Gray conversion
// ---------------------------------------------------------------------------
package gray_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SAT_HI = 2'd1,
        SAT_LO = 2'd2
    } gray_state_t;

    // Callers zero-extend into MAX_WIDTH and size-cast the result back down,
    // so one function serves every counter width up to MAX_WIDTH.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_step_counter.sv
// ---------------------------------------------------------------------------
// gray_step_counter
// Registered up/down Gray-code counter with synchronous parallel load and
// wrap-or-saturate behaviour at the ends of the binary range.
//
// Parameters
//   WIDTH : counter and Gray word width (>= 2, <= gray_pkg::MAX_WIDTH)
//   WRAP  : 1 = wrap around at the range ends, 0 = saturate there
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   en       in   step request, one step per cycle while high
//   up       in   direction, 1 = increment, 0 = decrement (binary domain)
//   load     in   synchronous load strobe, wins over en
//   load_val in   binary value to load
//   g        out  registered Gray-coded count
//   tc       out  registered terminal-count flag for the current direction
//   wrap     out  registered one-cycle pulse on wrap-around
//   sat      out  registered, high while held at a range end (WRAP = 0)
// ---------------------------------------------------------------------------
module gray_step_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] g,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] bcnt;
    logic [WIDTH-1:0] bcnt_next;
    gray_state_t      state;
    gray_state_t      state_next;
    logic             wrap_next;
    logic             tc_next;

    // Next-state decode. Priority is load, then en, then hold. The range
    // ends are detected explicitly so wrap-around never depends on the
    // adder truncating. Saturation parks the counter at the end it ran
    // into; stepping away from that end simply resumes normal counting.
    always_comb begin
        bcnt_next  = bcnt;
        state_next = state;
        wrap_next  = 1'b0;
        tc_next    = 1'b0;

        if (load) begin
            bcnt_next  = load_val;
            state_next = RUN;
        end else if (en) begin
            if (up) begin
                if (bcnt != MAX) begin
                    bcnt_next  = bcnt + ONE;
                    state_next = RUN;
                end else if (WRAP) begin
                    bcnt_next = '0;
                    wrap_next = 1'b1;
                end else begin
                    state_next = SAT_HI;
                end
            end else begin
                if (bcnt != '0) begin
                    bcnt_next  = bcnt - ONE;
                    state_next = RUN;
                end else if (WRAP) begin
                    bcnt_next = MAX;
                    wrap_next = 1'b1;
                end else begin
                    state_next = SAT_LO;
                end
            end
        end

        // Terminal count looks at the value we are about to hold and the
        // direction presented this cycle, so it is refreshed on hold edges
        // too and follows a direction change one cycle later.
        tc_next = up ? (bcnt_next == MAX) : (bcnt_next == '0);
    end

    // All state and every output is registered on the same edge. g is
    // derived from bcnt_next rather than bcnt so it stays aligned with the
    // binary count and only ever moves by a single bit per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt  <= '0;
            state <= RUN;
            g     <= '0;
            tc    <= 1'b0;
            wrap  <= 1'b0;
            sat   <= 1'b0;
        end else begin
            bcnt  <= bcnt_next;
            state <= state_next;
            g     <= WIDTH'(bin2gray(MAX_WIDTH'(bcnt_next)));
            tc    <= tc_next;
            wrap  <= wrap_next;
            sat   <= (state_next != RUN);
        end
    end

endmodule

// File: tb/tb_gray_step_counter.sv
// ---------------------------------------------------------------------------
// tb_gray_step_counter
// Drives a wrapping and a saturating instance of gray_step_counter with the
// same inputs. The driver pushes expected responses from an arithmetic
// reference model into per-instance queues; a monitor pops them after each
// clock edge and compares, decoding g back to binary along the way.
// ---------------------------------------------------------------------------
module tb_gray_step_counter;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    typedef struct {
        int cnt;
        bit tc;
        bit wrp;
        bit sat;
        bit chg;
        bit step;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;

    logic [W-1:0] g_w;
    logic         tc_w;
    logic         wrap_w;
    logic         sat_w;
    logic [W-1:0] g_s;
    logic         tc_s;
    logic         wrap_s;
    logic         sat_s;

    int  checks = 0;
    int  errors = 0;
    sb_t exp_w_q[$];
    sb_t exp_s_q[$];
    int  m_cnt[2];
    bit  m_sat[2];

    always #5 clk = ~clk;

    gray_step_counter #(.WIDTH(W), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .g(g_w), .tc(tc_w), .wrap(wrap_w), .sat(sat_w)
    );

    gray_step_counter #(.WIDTH(W), .WRAP(1'b0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .g(g_s), .tc(tc_s), .wrap(wrap_s), .sat(sat_s)
    );

    // Downstream decoder: each binary bit is the XOR of all Gray bits at
    // and above it.
    function automatic int gray2bin(input logic [W-1:0] gv);
        int b = 0;
        int acc = 0;
        for (int i = W - 1; i >= 0; i--) begin
            acc = acc ^ int'(gv[i]);
            b   = b | (acc << i);
        end
        return b;
    endfunction

    function automatic int gray_of(input int v);
        return v ^ (v >> 1);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: counts in plain integers; index 0 wraps, index 1
    // saturates. An out-of-range target either folds modulo 2^W or is
    // refused, which is all the wrap/saturate distinction amounts to.
    task automatic modelStep(input int idx, input bit e, input bit u, input bit l,
                             input int lv, output sb_t r);
        int old;
        int tgt;
        old   = m_cnt[idx];
        r.wrp = 1'b0;
        if (l) begin
            m_cnt[idx] = lv;
            m_sat[idx] = 1'b0;
        end else if (e) begin
            tgt = u ? old + 1 : old - 1;
            if (tgt > MAXV || tgt < 0) begin
                if (idx == 0) begin
                    m_cnt[idx] = (tgt + MAXV + 1) % (MAXV + 1);
                    r.wrp      = 1'b1;
                end else begin
                    m_sat[idx] = 1'b1;
                end
            end else begin
                m_cnt[idx] = tgt;
                m_sat[idx] = 1'b0;
            end
        end
        r.cnt  = m_cnt[idx];
        r.sat  = m_sat[idx];
        r.tc   = u ? (r.cnt == MAXV) : (r.cnt == 0);
        r.chg  = (r.cnt != old);
        r.step = e && !l;
    endtask

    task automatic applyStimulus(input bit e, input bit u, input bit l, input int lv);
        sb_t r;
        @(negedge clk);
        en       = e;
        up       = u;
        load     = l;
        load_val = W'(lv);
        modelStep(0, e, u, l, lv, r);
        exp_w_q.push_back(r);
        modelStep(1, e, u, l, lv, r);
        exp_s_q.push_back(r);
    endtask

    // Reset is pulled between edges and the outputs are checked before any
    // further clock edge arrives.
    task automatic applyReset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst.g_w", int'(g_w), 0);
        checkOutput("rst.tc_w", int'(tc_w), 0);
        checkOutput("rst.wrap_w", int'(wrap_w), 0);
        checkOutput("rst.g_s", int'(g_s), 0);
        checkOutput("rst.sat_s", int'(sat_s), 0);
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_sat[0] = 1'b0;
        m_sat[1] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic checkDut(input string tag, input sb_t e, input logic [W-1:0] gv,
                            input logic tcv, input logic wrv, input logic sav,
                            input logic [W-1:0] prev);
        checkOutput($sformatf("%s.g", tag), int'(gv), gray_of(e.cnt));
        checkOutput($sformatf("%s.decoded", tag), gray2bin(gv), e.cnt);
        checkOutput($sformatf("%s.tc", tag), int'(tcv), int'(e.tc));
        checkOutput($sformatf("%s.wrap", tag), int'(wrv), int'(e.wrp));
        checkOutput($sformatf("%s.sat", tag), int'(sav), int'(e.sat));
        if (e.step)
            checkOutput($sformatf("%s.onebit", tag), $countones(prev ^ gv), e.chg ? 1 : 0);
    endtask

    // Monitor: one expected entry per driven edge, sampled 1 time unit
    // after the rising edge.
    initial begin
        logic [W-1:0] prev_w;
        logic [W-1:0] prev_s;
        sb_t          e;
        prev_w = '0;
        prev_s = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                prev_w = '0;
                prev_s = '0;
            end else begin
                #1;
                if (exp_w_q.size() > 0) begin
                    e = exp_w_q.pop_front();
                    checkDut("wrap_dut", e, g_w, tc_w, wrap_w, sat_w, prev_w);
                end
                if (exp_s_q.size() > 0) begin
                    e = exp_s_q.pop_front();
                    checkDut("sat_dut", e, g_s, tc_s, wrap_s, sat_s, prev_s);
                end
                prev_w = g_w;
                prev_s = g_s;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seq[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = '0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_sat[0] = 1'b0;
        m_sat[1] = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("init.g_w", int'(g_w), 0);
        checkOutput("init.tc_w", int'(tc_w), 0);
        checkOutput("init.sat_s", int'(sat_s), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Full upward lap with wrap.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0);
            @(posedge clk);
            #2;
            checkOutput($sformatf("t1.g[%0d]", i + 1), int'(g_w), seq[i + 1]);
            if (i == 14) checkOutput("t1.tc_at_8", int'(tc_w), 1);
            if (i == 15) checkOutput("t1.wrap_at_0", int'(wrap_w), 1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        @(posedge clk);
        #2;
        checkOutput("t1.wrap_cleared", int'(wrap_w), 0);

        // Downward from reset.
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        @(posedge clk);
        #2;
        checkOutput("t2.g_8", int'(g_w), 8);
        checkOutput("t2.wrap", int'(wrap_w), 1);
        checkOutput("t2.sat_lo", int'(sat_s), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        @(posedge clk);
        #2;
        checkOutput("t2.g_9", int'(g_w), 9);
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        @(posedge clk);
        #2;
        checkOutput("t2.g_B", int'(g_w), 11);
        for (int i = 0; i < 13; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0);
        @(posedge clk);
        #2;
        checkOutput("t2.g_0", int'(g_w), 0);
        checkOutput("t2.tc_down", int'(tc_w), 1);

        // Load beats en.
        applyStimulus(1'b1, 1'b1, 1'b1, 10);
        @(posedge clk);
        #2;
        checkOutput("t3.load_g", int'(g_w), 15);
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        @(posedge clk);
        #2;
        checkOutput("t3.step_g", int'(g_w), 14);

        // Saturation on the WRAP=0 instance.
        applyStimulus(1'b0, 1'b1, 1'b1, 15);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 0);
            @(posedge clk);
            #2;
            checkOutput("t4.held_g", int'(g_s), 8);
            checkOutput("t4.sat", int'(sat_s), 1);
            checkOutput("t4.no_wrap", int'(wrap_s), 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        @(posedge clk);
        #2;
        checkOutput("t4.leave_g", int'(g_s), 9);
        checkOutput("t4.leave_sat", int'(sat_s), 0);

        // Asynchronous reset mid-count.
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 0);
        @(posedge clk);
        #2;
        checkOutput("t5.g_6", int'(g_w), 6);
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        @(posedge clk);
        #2;
        checkOutput("t5.first_step", int'(g_w), 1);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 15) == 0, int'($urandom_range(0, MAXV)));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 0);

        repeat (3) @(posedge clk);
        #2;
        checkOutput("drain.wrap_q", exp_w_q.size(), 0);
        checkOutput("drain.sat_q", exp_s_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
